// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   A chain of DEPTH valid/payload register stages with per-stage ready/valid
//   flow control. Bubbles collapse, so a stage moves forward whenever the stage
//   after it is empty or moving in the same cycle. When the chain is unstalled,
//   an entry takes exactly DEPTH cycles to travel from the input to the output,
//   and one entry per cycle can pass through.
//
//   Optional feature (macro PIPE_STAGE_CHAIN_SKID_EN): a one-entry skid buffer
//   ahead of S0. It makes in_ready_o a pure register output and raises the
//   capacity to DEPTH+1.
//
// Parameters
//   WIDTH        payload bits per entry
//   DEPTH        number of register stages (1..8)
//
// Ports
//   clk_i        clock; all state updates on its rising edge
//   rst_i        synchronous active-high reset; clears valids and payloads
//   flush_i      invalidates every stage (and the skid entry) at the next edge
//   in_valid_i   upstream entry present
//   in_ready_o   chain accepts an entry this cycle
//   in_data_i    upstream payload
//   out_valid_o  last stage holds a valid entry
//   out_ready_i  downstream consumes the entry this cycle
//   out_data_o   payload of the last stage (driven directly by a register)
//   occupancy_o  registered count of valid entries, including the skid entry
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  output logic [$clog2(DEPTH+2)-1:0]   occupancy_o
);

  localparam int OccW = $clog2(DEPTH+2);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] adv;      // stage k hands its entry forward this edge
  logic [DEPTH-1:0] load;     // stage k captures a new entry this edge
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [OccW-1:0]  occ_q, occ_d;

  logic             s0_space;  // S0 is empty or moving forward
  logic             s0_load;
  logic [WIDTH-1:0] s0_src;
  logic             in_fire;
  logic             out_fire;

  // Stall detection walks from the output back to S0. A stage is blocked only
  // if every stage downstream of it is valid and the output is not consumed.
  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic blocked;
    adv     = '0;
    blocked = !out_ready_i;
    for (int k = DEPTH-1; k >= 0; k--) begin
      adv[k]  = valid_q[k] && !blocked;
      blocked = valid_q[k] && blocked;
    end
  end

  assign s0_space    = !valid_q[0] || adv[0];
  assign out_fire    = valid_q[DEPTH-1] && out_ready_i;
  assign out_valid_o = valid_q[DEPTH-1];
  assign out_data_o  = data_q[DEPTH-1];
  assign occupancy_o = occ_q;

`ifdef PIPE_STAGE_CHAIN_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q;

  // The skid entry is older than anything on the input, so it has priority
  // into S0. in_ready_o is low whenever the skid buffer is occupied.
  assign in_ready_o = !skid_valid_q;
  assign in_fire    = in_valid_i && !skid_valid_q;
  assign s0_load    = (skid_valid_q || in_valid_i) && s0_space;
  assign s0_src     = skid_valid_q ? skid_data_q : in_data_i;

  always_comb begin
    skid_valid_d = skid_valid_q;
    if (skid_valid_q) skid_valid_d = !s0_space;
    else              skid_valid_d = in_fire && !s0_space;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= flush_i ? 1'b0 : skid_valid_d;
      if (!skid_valid_q && in_fire) skid_data_q <= in_data_i;
    end
  end
`else
  assign in_ready_o = s0_space;
  assign in_fire    = in_valid_i && s0_space;
  assign s0_load    = in_fire;
  assign s0_src     = in_data_i;
`endif

  always_comb begin
    load  = '0;
    load[0] = s0_load;
    for (int k = 1; k < DEPTH; k++) load[k] = adv[k-1];
    for (int k = 0; k < DEPTH; k++) valid_d[k] = load[k] || (valid_q[k] && !adv[k]);
    occ_d = occ_q + OccW'(in_fire) - OccW'(out_fire);
  end

  // Payload registers are cleared on reset so out_data_o reads 0 afterwards.
  // NOTE: the payload array is reset explicitly here (not left as a RAM) because
  // the reset value is visible at out_data_o.
  // NOTE: state uses non-blocking assignments so every stage samples the value
  // its neighbour held before this edge, which is what makes the shift work.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      valid_q <= flush_i ? '0 : valid_d;
      occ_q   <= flush_i ? '0 : occ_d;
      // Payloads keep moving under flush; they are unobservable once invalid.
      if (load[0]) data_q[0] <= s0_src;
      for (int k = 1; k < DEPTH; k++) begin
        if (load[k]) data_q[k] <= data_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_chain
//   Self-checking bench for pipe_stage_chain with DEPTH=3 and WIDTH=64. A table
//   of per-cycle vectors covers streaming, full-chain throughput and reset
//   mid-stream. Hand-written sequences cover backpressure fill/drain, flush and
//   a lone entry under a toggling out_ready_i.
// -----------------------------------------------------------------------------
module tb_pipe_stage_chain;

  localparam int W = 64;
  localparam int D = 3;
`ifdef PIPE_STAGE_CHAIN_SKID_EN
  localparam int CAP = D + 1;
`else
  localparam int CAP = D;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   occ;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .occupancy_o (occ)
  );

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         e_ov;
    logic         e_chk;   // compare out_data even when out_valid is low
    logic [W-1:0] e_data;
    logic         e_ir;
    logic [2:0]   e_occ;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic r, input logic iv, input logic [W-1:0] id, input logic ordy,
                     input logic ov, input logic chk, input logic [W-1:0] od,
                     input logic ir, input logic [2:0] oc);
    vec_t v;
    v = '{rst: r, iv: iv, id: id, ordy: ordy, e_ov: ov, e_chk: chk,
          e_data: od, e_ir: ir, e_occ: oc};
    tbl.push_back(v);
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [W-1:0] d, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick();
  endtask

  // Stream three entries through an unstalled chain and drain it.
  task automatic add_stream(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    add(0, 1, a,  1, 0, 0, 0, 1, 0);
    add(0, 1, b,  1, 0, 0, 0, 1, 1);
    add(0, 1, c,  1, 0, 0, 0, 1, 2);
    add(0, 0, '0, 1, 1, 0, a, 1, 3);
    add(0, 0, '0, 1, 1, 0, b, 1, 2);
    add(0, 0, '0, 1, 1, 0, c, 1, 1);
    add(0, 0, '0, 1, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int acc, got, seen, deliv;

    // Stream after reset.
    add_stream(64'h11, 64'h22, 64'h33);
    // Fill with output stalled, then stream with the chain full.
    add(0, 1, 64'hA1, 0, 0, 0, 0,      1, 0);
    add(0, 1, 64'hA2, 0, 0, 0, 0,      1, 1);
    add(0, 1, 64'hA3, 0, 0, 0, 0,      1, 2);
    add(0, 1, 64'hA4, 1, 1, 0, 64'hA1, 1, 3);
    add(0, 1, 64'hA5, 1, 1, 0, 64'hA2, 1, 3);
    add(0, 1, 64'hA6, 1, 1, 0, 64'hA3, 1, 3);
    add(0, 0, '0,     1, 1, 0, 64'hA4, 1, 3);
    add(0, 0, '0,     1, 1, 0, 64'hA5, 1, 2);
    add(0, 0, '0,     1, 1, 0, 64'hA6, 1, 1);
    add(0, 0, '0,     1, 0, 0, 0,      1, 0);
    // Reset with two entries held, then a fresh stream.
    add(0, 1, 64'hB1, 0, 0, 0, 0,      1, 0);
    add(0, 1, 64'hB2, 0, 0, 0, 0,      1, 1);
    add(1, 0, '0,     0, 0, 0, 0,      1, 2);
    add(0, 0, '0,     0, 0, 1, 0,      1, 0);
    add_stream(64'h55, 64'h66, 64'h77);

    do_reset();
    tick();
    foreach (tbl[i]) begin
      drive(tbl[i].rst, 1'b0, tbl[i].iv, tbl[i].id, tbl[i].ordy);
      check($sformatf("v%0d out_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      check($sformatf("v%0d in_ready", i),  W'(in_ready),  W'(tbl[i].e_ir));
      check($sformatf("v%0d occupancy", i), W'(occ),       W'(tbl[i].e_occ));
      if (tbl[i].e_ov || tbl[i].e_chk)
        check($sformatf("v%0d out_data", i), out_data, tbl[i].e_data);
      tick();
    end

    // Backpressure: input held for 6 cycles with output stalled.
    do_reset();
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 1'b1, 64'h100 + W'(acc), 1'b0);
      if (in_ready) acc++;
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("bp accepted", W'(acc), W'(CAP));
    check("bp in_ready", W'(in_ready), '0);
    check("bp occupancy", W'(occ), W'(CAP));
    got = 0;
    for (int c = 0; c < 20 && got < CAP; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      if (out_valid) begin
        check($sformatf("bp drain %0d", got), out_data, 64'h100 + W'(got));
        got++;
      end
      tick();
    end
    check("bp drained count", W'(got), W'(CAP));

    // Flush with three entries held and 0x44 offered in the same cycle.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 64'h31 + W'(i), 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 1'b1, 64'h44, 1'b1);
    check("flush pre occupancy", W'(occ), 64'd3);
    check("flush out transfer", out_data, 64'h31);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("flush out_valid", W'(out_valid), '0);
    check("flush occupancy", W'(occ), '0);
    check("flush in_ready", W'(in_ready), 64'd1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
      if (out_valid) seen++;
      tick();
    end
    check("flush nothing emerges", W'(seen), '0);

    // Lone 0xAA with a gap and out_ready toggling: delivered once, unchanged.
    do_reset();
    deliv = 0;
    for (int c = 0; c < 12; c++) begin
      drive(1'b0, 1'b0, c == 0, 64'hAA, (c % 2) == 0);
      if (out_valid) check($sformatf("lone data c%0d", c), out_data, 64'hAA);
      if (out_valid && out_ready) deliv++;
      tick();
    end
    check("lone delivered once", W'(deliv), 64'd1);
    check("lone final out_valid", W'(out_valid), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
